branch_resolve_ctrl: RTL and testbench
======================================

# branch_resolve_ctrl

Sequencer for the 4-entry 2-bit branch predictor. It sits between the IF and ID stages and captures each predicted beq/bne leaving IF together with its prediction, target and fall-through PC. When the branch is resolved in ID, it produces the predictor's 2-bit update code, the table index and the mispredict redirect/flush to the PC and IF/ID registers. It also keeps saturating branch and mispredict counters for performance reporting.

## Interface
- ADDR_W, 32, PC width
- CNT_W, 16, width of each statistics counter
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- stall  in  1  global pipeline stall; 1 freezes IF/ID
- flush_ext  in  1  ID instruction squashed by another source (jump, exception)
- if_valid  in  1  IF holds a valid instruction
- if_is_br  in  1  IF instruction is beq/bne
- if_br_pre  in  1  predictor output for the IF instruction
- if_pc  in  ADDR_W  PC of the IF instruction
- if_target  in  ADDR_W  branch target computed in IF
- id_taken  in  1  actual outcome of the branch in ID; sampled only in TRACK
- pre_wrong  out  2  00 correct, 01 predicted taken but not taken, 11 predicted not-taken but taken, 10 no update
- upd_idx  out  2  predictor entry to update, equal to the captured pc[3:2]
- redirect_valid  out  1  load redirect_pc into the PC this cycle
- redirect_pc  out  ADDR_W  corrected fetch address
- flush_if_id  out  1  squash the IF instruction this cycle
- br_cnt, mis_cnt  out  CNT_W  resolved branches / mispredicts, saturating

## Operation
- Captured registers:
  - tag: pc[3:2]
  - pred
  - tgt
  - fall: pc+4, computed modulo 2^ADDR_W
- FSM states: IDLE, TRACK.
- cap = !stall & if_valid & if_is_br & !flush_if_id & !flush_ext.
- IDLE:
  - pre_wrong=10, redirect_valid=0, flush_if_id=0.
  - On cap, load the captured registers and go to TRACK.
- TRACK with stall=1: hold all state; pre_wrong=10; no redirect or flush.
- TRACK with flush_ext=1 (priority over resolution): pre_wrong=10; go to IDLE, or reload on cap (cap is 0 by definition, so IDLE).
- TRACK with stall=0 resolves:
  - mis = pred ^ id_taken.
  - pre_wrong = mis ? (pred ? 01 : 11) : 00.
  - br_cnt++ (saturating).
  - If mis: mis_cnt++ (saturating), redirect_valid=1, flush_if_id=1, redirect_pc = id_taken ? tgt : fall; next state IDLE, with no capture because the IF instruction is squashed.
  - If correct: no redirect. On cap, reload and stay in TRACK (back-to-back branches); otherwise go to IDLE.
- upd_idx=tag at all times; it is meaningful only when pre_wrong!=10.
- Both counters stop at 2^CNT_W-1 and are never cleared except by reset.

## Timing
- Reset values:
  - state IDLE
  - tag, pred, tgt, fall, br_cnt, mis_cnt all 0
  - pre_wrong=10, redirect_valid=0, flush_if_id=0, redirect_pc=0
- pre_wrong, redirect_valid, redirect_pc and flush_if_id are combinational from registered state, id_taken, stall and flush_ext. They are valid in the same cycle the branch sits unstalled in ID; the predictor and PC consume them at the next clk edge.
- Latency from capture edge to resolution is 1 cycle plus the number of stalled cycles.
- Mispredict penalty is exactly 1 squashed IF slot.
- Capture and resolution in the same cycle are legal when the resolved branch was predicted correctly.
- A reset asserted mid-TRACK abandons the branch with no update and no redirect.

## Structure
- Shared package (br_pkg): 2-bit PreWrong encodings (PW_OK=00, PW_FALSE_TAKEN=01, PW_NONE=10, PW_MISSED_TAKEN=11), FSM state encoding, and the index slice position [3:2].
- Sub-module br_sat_counter (parameter CNT_W, inc input, saturating) is instantiated twice.
- The datapath registers and FSM stay in the top level.

## Test plan
- Reset, then if_pc=0x100 beq with pred=1, if_target=0x140, then id_taken=1 -> next cycle pre_wrong=00, upd_idx=0, no redirect, br_cnt=1.
- Same branch with pred=1 and id_taken=0 -> pre_wrong=01, redirect_valid=1, redirect_pc=0x104, flush_if_id=1, mis_cnt=1, state IDLE.
- if_pc=0x10C with pred=0, if_target=0x080, id_taken=1 -> pre_wrong=11, upd_idx=3, redirect_pc=0x080.
- Branch in TRACK with stall held for 3 cycles -> pre_wrong=10 and no counter change during the stall. Resolution occurs in the first unstalled cycle with the captured values intact.
- Two correctly predicted back-to-back branches at 0x200 and 0x204 -> state stays TRACK, upd_idx 0 then 1, br_cnt=2. Then flush_ext during TRACK -> pre_wrong=10, IDLE.
- if_pc=0xFFFFFFFC with pred=1 and id_taken=0 -> redirect_pc=0x00000000 (wrap). With CNT_W=2, 5 mispredicts -> mis_cnt saturates at 3.

Source files
------------

// File: rtl/br_pkg.sv
// rtl/br_pkg.sv - shared encodings for the branch resolve sequencer
package br_pkg;

    typedef enum logic [1:0] {
        PW_OK           = 2'b00,
        PW_FALSE_TAKEN  = 2'b01,
        PW_NONE         = 2'b10,
        PW_MISSED_TAKEN = 2'b11
    } pre_wrong_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_TRACK = 1'b1
    } br_state_t;

    // Predictor table index is taken from these PC bits.
    localparam int IDX_MSB = 3;
    localparam int IDX_LSB = 2;

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// rtl/branch_resolve_ctrl_if.sv - pipeline-side bundle of the branch resolve sequencer
interface branch_resolve_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              flush_ext;
    logic              if_valid;
    logic              if_is_br;
    logic              if_br_pre;
    logic [ADDR_W-1:0] if_pc;
    logic [ADDR_W-1:0] if_target;
    logic              id_taken;
    logic [1:0]        pre_wrong;
    logic [1:0]        upd_idx;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              flush_if_id;
    logic [CNT_W-1:0]  br_cnt;
    logic [CNT_W-1:0]  mis_cnt;

    modport master (
        output stall, flush_ext, if_valid, if_is_br, if_br_pre, if_pc, if_target, id_taken,
        input  pre_wrong, upd_idx, redirect_valid, redirect_pc, flush_if_id, br_cnt, mis_cnt
    );

    modport slave (
        input  stall, flush_ext, if_valid, if_is_br, if_br_pre, if_pc, if_target, id_taken,
        output pre_wrong, upd_idx, redirect_valid, redirect_pc, flush_if_id, br_cnt, mis_cnt
    );
endinterface

// File: rtl/br_sat_counter.sv
// rtl/br_sat_counter.sv - saturating event counter, cleared only by reset
module br_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - tracks one predicted branch from IF to ID and
// produces predictor update, mispredict redirect/flush and statistics.
module branch_resolve_ctrl
    import br_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_resolve_ctrl_if.slave  bus
);

    br_state_t         state;
    logic [1:0]        tag;
    logic              pred;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] fall;

    logic resolve;
    logic mis;
    logic squash;
    logic cap;

    always_comb begin
        resolve = (state == ST_TRACK) && !bus.stall && !bus.flush_ext;
        mis     = pred ^ bus.id_taken;
        squash  = resolve && mis;
        // A mispredict squashes the IF slot, so it can never be captured.
        cap     = !bus.stall && bus.if_valid && bus.if_is_br && !squash && !bus.flush_ext;

        bus.pre_wrong      = PW_NONE;
        bus.redirect_valid = 1'b0;
        bus.flush_if_id    = 1'b0;
        bus.redirect_pc    = '0;
        if (resolve) begin
            if (mis) begin
                bus.pre_wrong      = pred ? PW_FALSE_TAKEN : PW_MISSED_TAKEN;
                bus.redirect_valid = 1'b1;
                bus.flush_if_id    = 1'b1;
                bus.redirect_pc    = bus.id_taken ? tgt : fall;
            end else begin
                bus.pre_wrong = PW_OK;
            end
        end
    end

    assign bus.upd_idx = tag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            tag   <= '0;
            pred  <= 1'b0;
            tgt   <= '0;
            fall  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cap) begin
                        state <= ST_TRACK;
                        tag   <= bus.if_pc[IDX_MSB:IDX_LSB];
                        pred  <= bus.if_br_pre;
                        tgt   <= bus.if_target;
                        fall  <= bus.if_pc + ADDR_W'(4);
                    end
                end
                ST_TRACK: begin
                    // Stall freezes everything; otherwise the branch leaves ID
                    // (resolved or flushed) and a correct one may be replaced.
                    if (!bus.stall) begin
                        if (cap) begin
                            state <= ST_TRACK;
                            tag   <= bus.if_pc[IDX_MSB:IDX_LSB];
                            pred  <= bus.if_br_pre;
                            tgt   <= bus.if_target;
                            fall  <= bus.if_pc + ADDR_W'(4);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    br_sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (resolve),
        .cnt   (bus.br_cnt)
    );

    br_sat_counter #(.CNT_W(CNT_W)) u_mis_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (squash),
        .cnt   (bus.mis_cnt)
    );

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - scoreboard bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    typedef struct {
        logic [1:0]  pw;
        logic [1:0]  idx;
        logic        rv;
        logic [31:0] rpc;
        logic        fl;
        int          bc;
        int          mc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    branch_resolve_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Reference model: at most one branch is pending between IF and ID.
    bit          have_br;
    logic [31:0] br_pc;
    logic [31:0] br_tgt;
    bit          br_pred;
    logic [31:0] last_pc;
    int          n_br;
    int          n_mis;

    task automatic model_reset();
        have_br = 0; br_pc = 0; br_tgt = 0; br_pred = 0;
        last_pc = 0; n_br = 0; n_mis = 0;
    endtask

    task automatic drive(input bit r, input bit s, input bit f, input bit v, input bit b,
                         input bit p, input logic [31:0] pc, input logic [31:0] tg, input bit tk);
        exp_t e;
        bit res, mis, cap;
        @(posedge clk);
        #1;
        rst_n         = r;
        bus.stall     = s;
        bus.flush_ext = f;
        bus.if_valid  = v;
        bus.if_is_br  = b;
        bus.if_br_pre = p;
        bus.if_pc     = pc;
        bus.if_target = tg;
        bus.id_taken  = tk;
        if (!r) begin
            model_reset();
            return;
        end
        res = have_br && !s && !f;
        mis = res && (br_pred != tk);
        e.pw  = !res ? 2'b10 : (!mis ? 2'b00 : (br_pred ? 2'b01 : 2'b11));
        e.idx = last_pc[3:2];
        e.rv  = mis;
        e.fl  = mis;
        e.rpc = !mis ? 32'h0 : (tk ? br_tgt : br_pc + 32'd4);
        e.bc  = n_br;
        e.mc  = n_mis;
        exp_q.push_back(e);
        cap = !s && v && b && !mis && !f;
        if (have_br && !s) begin
            have_br = 0;
            if (res) begin
                if (n_br < CMAX) n_br++;
                if (mis && n_mis < CMAX) n_mis++;
            end
        end
        if (cap) begin
            have_br = 1; br_pc = pc; br_tgt = tg; br_pred = p; last_pc = pc;
        end
    endtask

    task automatic idle(input bit tk);
        drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, tk);
    endtask

    task automatic br(input logic [31:0] pc, input bit p, input logic [31:0] tg);
        drive(1, 0, 0, 1, 1, p, pc, tg, 0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pre_wrong", 32'(bus.pre_wrong), 32'(e.pw));
                check("upd_idx", 32'(bus.upd_idx), 32'(e.idx));
                check("redirect_valid", 32'(bus.redirect_valid), 32'(e.rv));
                check("redirect_pc", bus.redirect_pc, e.rpc);
                check("flush_if_id", 32'(bus.flush_if_id), 32'(e.fl));
                check("br_cnt", 32'(bus.br_cnt), 32'(e.bc));
                check("mis_cnt", 32'(bus.mis_cnt), 32'(e.mc));
            end
        end
    end

    initial begin : stimulus
        int t;
        bus.stall = 0; bus.flush_ext = 0; bus.if_valid = 0; bus.if_is_br = 0;
        bus.if_br_pre = 0; bus.if_pc = 0; bus.if_target = 0; bus.id_taken = 0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        // correct taken prediction
        br(32'h100, 1, 32'h140);
        idle(1);
        idle(0);
        // predicted taken, not taken
        br(32'h100, 1, 32'h140);
        idle(0);
        idle(0);
        // predicted not-taken, taken
        br(32'h10C, 0, 32'h080);
        idle(1);
        idle(0);
        // resolution held off by a 3-cycle stall
        br(32'h108, 1, 32'h300);
        repeat (3) drive(1, 1, 0, 1, 1, 0, 32'h500, 32'h600, 0);
        idle(1);
        // back-to-back correct branches, then external flush
        br(32'h200, 1, 32'h240);
        drive(1, 0, 0, 1, 1, 0, 32'h204, 32'h280, 1);
        drive(1, 0, 1, 0, 0, 0, 32'h0, 32'h0, 1);
        idle(0);
        // fall-through wraps around the address space
        br(32'hFFFF_FFFC, 1, 32'h10);
        idle(0);
        // mispredicts past counter saturation
        repeat (3) begin
            br(32'h104, 0, 32'h20);
            idle(1);
        end
        // reset in the middle of tracking abandons the branch
        br(32'h10C, 1, 32'h44);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        idle(1);
        for (int i = 0; i < 400; i++) begin
            bit s, f;
            s = ($urandom_range(0, 3) == 0);
            f = s ? 1'b0 : ($urandom_range(0, 9) == 0);
            drive(($urandom_range(0, 63) != 0), s, f,
                  ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) < 3),
                  1'($urandom), {$urandom} & 32'hFFFF_FFFC, {$urandom}, 1'($urandom));
        end
        idle(0);
        t = 0;
        while (exp_q.size() > 0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
